// File: rtl/mv_sequencer.sv
// mv_sequencer: sequences one N x N matrix-vector product through an external
// multiply-accumulate unit, one matrix row at a time.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     begin a pass (only honoured in IDLE)
//   abort     cancel a pass in progress
//   busy      high whenever not IDLE
//   done      one-cycle pulse at the end of a completed pass
//   mem_en    operand read enable (memories answer one cycle later)
//   mat_addr  row-major matrix element address
//   vec_addr  vector element address
//   mac_clr   accumulator clear
//   mac_en    accumulate enable (mem_en delayed by one cycle)
//   mac_f     accumulator value from the MAC
//   res_we    result write strobe, once per row
//   res_addr  result row index
//   res_data  combinational copy of mac_f
module mv_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned MW = $clog2(N * N),
    parameter int unsigned VW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_en,
    output logic [MW-1:0]        mat_addr,
    output logic [VW-1:0]        vec_addr,
    output logic                 mac_clr,
    output logic                 mac_en,
    input  logic signed [15:0]   mac_f,
    output logic                 res_we,
    output logic [VW-1:0]        res_addr,
    output logic signed [15:0]   res_data
);

    localparam int unsigned  DW     = 16;
    localparam logic [VW-1:0] LAST  = VW'(N - 1);
    localparam logic [MW-1:0] NCOLS = MW'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [VW-1:0]   r_row;
    logic [VW-1:0]   w_row_nxt;
    logic [VW-1:0]   r_col;
    logic [VW-1:0]   w_col_nxt;
    logic            r_mac_en;
    logic            w_abort;

    // State, counters and the one-cycle mem_en -> mac_en delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_mac_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_mac_en <= mem_en;
        end
    end

    // Next state, counters and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        mem_en      = 1'b0;
        mat_addr    = '0;
        vec_addr    = '0;
        mac_clr     = 1'b0;
        res_we      = 1'b0;
        res_addr    = '0;
        // abort is meaningless in IDLE, so a same-cycle start always wins there
        w_abort     = abort && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    w_row_nxt   = '0;
                end
            end
            S_CLEAR: begin
                mac_clr     = 1'b1;
                w_col_nxt   = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                mem_en   = 1'b1;
                mat_addr = MW'(r_row) * NCOLS + MW'(r_col);
                vec_addr = r_col;
                if (r_col == LAST) begin
                    w_col_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_col_nxt = r_col + VW'(1);
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                res_we   = 1'b1;
                res_addr = r_row;
                if (r_row == LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_row_nxt   = r_row + VW'(1);
                    w_state_nxt = S_CLEAR;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition and silences the data-path strobes
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            mem_en      = 1'b0;
            res_we      = 1'b0;
            done        = 1'b0;
        end

        mac_en = r_mac_en && !w_abort;
    end

    // Result is the live accumulator; held at zero while reset is asserted
    assign res_data = reset ? mac_f : DW'(0);

endmodule

// File: tb/tb_mv_sequencer.sv
// tb_mv_sequencer: directed + randomized bench for mv_sequencer (N=4) with
// one-cycle-latency operand memories and an 8x8->16 signed MAC model.
module tb_mv_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned MW = 4;
    localparam int unsigned VW = 2;
    localparam int          PASS_LEN = 29;   // N*(N+3)+1
    localparam int          ROW_LEN  = 7;    // N+3

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 mem_en;
    logic [MW-1:0]        mat_addr;
    logic [VW-1:0]        vec_addr;
    logic                 mac_clr;
    logic                 mac_en;
    logic signed [15:0]   mac_f;
    logic                 res_we;
    logic [VW-1:0]        res_addr;
    logic signed [15:0]   res_data;

    int total = 0;
    int bad   = 0;

    mv_sequencer #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mat_addr (mat_addr),
        .vec_addr (vec_addr),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .mac_f    (mac_f),
        .res_we   (res_we),
        .res_addr (res_addr),
        .res_data (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memories and MAC environment
    logic signed [7:0]  mat [N*N];
    logic signed [7:0]  vec [N];
    logic signed [7:0]  op_a;
    logic signed [7:0]  op_b;
    logic signed [15:0] prod;

    always_comb prod = op_a * op_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a  <= '0;
            op_b  <= '0;
            mac_f <= '0;
        end else begin
            if (mem_en) begin
                op_a <= mat[mat_addr];
                op_b <= vec[vec_addr];
            end
            if (mac_clr)     mac_f <= '0;
            else if (mac_en) mac_f <= mac_f + prod;
        end
    end

    // Reference: row dot product wrapped to 16 bits
    function automatic logic signed [15:0] row_sum(input int r);
        int s;
        s = 0;
        for (int c = 0; c < N; c++) s += int'(mat[r*N+c]) * int'(vec[c]);
        return 16'(s);
    endfunction

    function automatic logic [5:0] flags();
        return {busy, done, mem_en, mac_clr, mac_en, res_we};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N*N; i++) mat[i] = 8'($urandom);
        for (int i = 0; i < N; i++)   vec[i] = 8'($urandom);
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("idle_flags", 32'(flags()), 32'(0));
        end
    endtask

    // Walks one pass from cycle k0 (0 = CLEAR of row 0, sampled just after the
    // start edge) and compares every cycle against the timeline the row
    // structure implies: CLEAR, N RUN, DRAIN, WRITE per row, then DONE.
    task automatic body(input int k0, input int abort_at, input bit repulse, input bit hold);
        logic [5:0] ef;
        int row, ph;
        for (int k = k0; k < PASS_LEN; k++) begin
            row = k / ROW_LEN;
            ph  = k % ROW_LEN;
            if (k == abort_at) begin
                abort = 1'b1;
                #1;
            end
            ef[5] = 1'b1;
            ef[4] = (k == PASS_LEN - 1);
            ef[3] = (k < PASS_LEN - 1) && (ph >= 1) && (ph <= N);
            ef[2] = (k < PASS_LEN - 1) && (ph == 0);
            ef[1] = (k < PASS_LEN - 1) && (ph >= 2) && (ph <= N + 1);
            ef[0] = (k < PASS_LEN - 1) && (ph == N + 2);
            if (k == abort_at) begin
                ef[4] = 1'b0; ef[3] = 1'b0; ef[1] = 1'b0; ef[0] = 1'b0;
            end
            chk($sformatf("flags_k%0d", k), 32'(flags()), 32'(ef));
            if (ef[3]) begin
                chk($sformatf("mat_addr_k%0d", k), 32'(mat_addr), 32'(row * N + ph - 1));
                chk($sformatf("vec_addr_k%0d", k), 32'(vec_addr), 32'(ph - 1));
            end
            if (ef[0]) begin
                chk($sformatf("res_addr_r%0d", row), 32'(res_addr), 32'(row));
                chk($sformatf("res_data_r%0d", row), 32'(res_data), 32'(row_sum(row)));
            end
            if (k == abort_at) begin
                tick();
                abort = 1'b0;
                chk("after_abort", 32'(flags()), 32'(0));
                idle_check(12);
                return;
            end
            if (repulse && k == 10) start = 1'b1;
            if (repulse && k == 11) start = 1'b0;
            tick();
        end
        chk("post_done_busy", 32'(flags()), 32'(0));
        if (hold) begin
            tick();
            start = 1'b0;
        end
    endtask

    task automatic do_pass(input int abort_at, input bit repulse, input bit hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        body(0, abort_at, repulse, hold);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < N*N; i++) mat[i] = '0;
        for (int i = 0; i < N; i++)   vec[i] = '0;
        #3;
        chk("reset_outputs", 32'({flags(), mat_addr, vec_addr, res_addr, res_data}), 32'(0));
        #19;
        reset = 1'b1;
        idle_check(2);

        // Identity matrix times [1,2,3,4]
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mat[r*N+c] = (r == c) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
        do_pass(-1, 1'b0, 1'b0);
        idle_check(2);

        // Signed row products
        fill_random();
        mat[0] = -8'sd1; mat[1] = 8'sd2; mat[2] = -8'sd3; mat[3] = 8'sd4;
        vec[0] = 8'sd5;  vec[1] = 8'sd6; vec[2] = 8'sd7;  vec[3] = 8'sd8;
        do_pass(-1, 1'b0, 1'b0);
        chk("signed_ref_18", 32'(row_sum(0)), 32'(18));

        fill_random();
        mat[0] = -8'sd128; mat[1] = -8'sd128; mat[2] = 8'sd0; mat[3] = 8'sd0;
        vec[0] = 8'sd127;  vec[1] = 8'sd127;  vec[2] = 8'sd0; vec[3] = 8'sd0;
        do_pass(-1, 1'b0, 1'b0);

        // Start re-pulsed mid-pass is ignored
        fill_random();
        do_pass(-1, 1'b1, 1'b0);

        // Abort during RUN of row 2, then a fresh complete pass
        fill_random();
        do_pass(2 * ROW_LEN + 2, 1'b0, 1'b0);
        fill_random();
        do_pass(-1, 1'b0, 1'b0);

        // Start held high: second pass begins two cycles after DONE
        fill_random();
        do_pass(-1, 1'b0, 1'b1);
        body(0, -1, 1'b0, 1'b0);

        // Abort alone in IDLE does nothing; abort with start in IDLE lets start win
        abort = 1'b1;
        idle_check(2);
        start = 1'b1;
        fill_random();
        tick();
        start = 1'b0;
        abort = 1'b0;
        body(0, -1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        fill_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_reset_mem_en", 32'(mem_en), 32'(1));
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({flags(), mat_addr, vec_addr, res_addr, res_data}), 32'(0));
        #2;
        reset = 1'b1;
        idle_check(PASS_LEN + 4);

        // Randomized passes
        for (int p = 0; p < 3; p++) begin
            fill_random();
            do_pass(-1, 1'b0, 1'b0);
            idle_check(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mv_sequencer.md
MV_SEQUENCER -- requirements
Module: mv_sequencer

Interface
REQ-001 Parameter N, default 4, matrix/vector dimension; legal range 2..16.
REQ-002 Parameter MW, default $clog2(N*N), matrix address width; VW, default $clog2(N), vector/result address width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low (reset=0 clears all state immediately, independent of clk).
REQ-005 start  input  1  request one full matrix-vector pass; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a pass in progress.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when a pass completes normally.
REQ-009 mem_en  output  1  operand read enable; matrix and vector memories return data one cycle later.
REQ-010 mat_addr  output  MW  matrix element address, row-major (row*N+col).
REQ-011 vec_addr  output  VW  vector element address (col).
REQ-012 mac_clr  output  1  active-high accumulator clear to the multiply-accumulate unit.
REQ-013 mac_en  output  1  accumulate enable; MAC adds a*b on the rising edge where mac_en=1.
REQ-014 mac_f  input  16  signed accumulator value from the MAC, registered, updated the edge after mac_en.
REQ-015 res_we  output  1  result write strobe, one cycle per row.
REQ-016 res_addr  output  VW  result row index.
REQ-017 res_data  output  16  signed row result; combinational copy of mac_f, meaningful only while res_we=1.

Function
REQ-018 FSM states: IDLE, CLEAR, RUN, DRAIN, WRITE, DONE; registered counters row and col, each 0..N-1.
REQ-019 IDLE: start=1 at an edge -> CLEAR, row=0; otherwise stay.
REQ-020 CLEAR: exactly one cycle; mac_clr=1, col=0 -> RUN.
REQ-021 RUN: exactly N cycles; mem_en=1, mat_addr=row*N+col, vec_addr=col; col increments each cycle; col=N-1 -> DRAIN.
REQ-022 mac_en is mem_en delayed one cycle by a register; mac_en=1 in cycles 2..N of RUN and in DRAIN; 0 everywhere else.
REQ-023 DRAIN: exactly one cycle (last accumulate) -> WRITE.
REQ-024 WRITE: exactly one cycle; res_we=1, res_addr=row; row=N-1 -> DONE, else row+1 -> CLEAR.
REQ-025 DONE: one cycle, done=1 -> IDLE.
REQ-026 Per-row cost N+3 cycles; pass length N*(N+3)+1 cycles from the start edge to the end of DONE (29 for N=4).
REQ-027 mac_clr and mac_en are never high in the same cycle; mem_en, mac_clr, res_we are 0 in IDLE and DONE.
REQ-028 start while busy=1 is ignored, never queued; start held high restarts a new pass from IDLE the cycle after DONE.
REQ-029 abort=1 in any non-IDLE state -> IDLE at the next edge; mem_en, mac_en, res_we forced 0 in the abort cycle; no done pulse; abort in IDLE has no effect.
REQ-030 abort and start in the same IDLE cycle: start wins; abort has priority over all transitions in every other state.
REQ-031 Sequencer performs no arithmetic on mac_f; 16-bit wrap/overflow belongs to the MAC.

Reset
REQ-032 reset=0: state IDLE, row=0, col=0, mac_en pipeline register 0, all outputs 0, asynchronously and regardless of state.
REQ-033 First edge after reset deasserts behaves as IDLE; a pass interrupted by reset is not resumed.

Verification (N=4, behavioural 1-cycle-latency memories and 8x8->16 signed MAC model)
REQ-034 Identity matrix, vector [1,2,3,4], start pulse -> res_we at rows 0..3 with res_data 1,2,3,4; done high exactly 29 cycles after start edge; busy falls with it.
REQ-035 Row 1 address check -> mat_addr 4,5,6,7 with vec_addr 0,1,2,3 on consecutive RUN cycles; mac_en lags mem_en by one cycle.
REQ-036 Signed: row 0 = [-1,2,-3,4], vector [5,6,7,8] -> res_addr 0, res_data 18; row 0 = [-128,-128,0,0], vector [127,127,0,0] -> res_data -32512.
REQ-037 abort during RUN of row 2 -> IDLE next cycle, no further res_we, no done; fresh start then completes a full correct pass.
REQ-038 start re-pulsed mid-pass -> ignored, timing unchanged; start held high -> second pass CLEAR begins 2 cycles after first DONE.
REQ-039 reset=0 asynchronously mid-RUN (between edges) -> all outputs 0 immediately, busy=0, no done after release.
